// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared constants and helpers for the BCD cook-timer digit chain.
//   BCD_W      : width of one BCD digit
//   digit_mod  : modulus of digit k (6 for the mm:ss seconds-tens digit, else 10)
//   bcd_clamp  : saturate a load nibble to the digit maximum
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int BCD_W = 4;

    function automatic int digit_mod(input int k, input bit sexagesimal);
        return (sexagesimal && (k == 1)) ? 6 : 10;
    endfunction

    // Invalid BCD nibbles (A-F) and out-of-range mm:ss tens values both
    // land on the digit maximum, so a single saturating compare covers both.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] value,
                                                   input logic [BCD_W-1:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/timer_digit.sv
// -----------------------------------------------------------------------------
// timer_digit
// One modulo-MOD down-counting BCD digit.
//   clk     in   system clock, rising edge
//   clrn    in   asynchronous active-low reset (value -> 0)
//   load    in   synchronous load of din (clamped to MOD-1), beats dec
//   din     in   load value
//   dec     in   decrement; at zero the digit reloads MOD-1 (borrow)
//   value   out  current digit
//   is_zero out  value == 0
// -----------------------------------------------------------------------------
module timer_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             load,
    input  logic [BCD_W-1:0] din,
    input  logic             dec,
    output logic [BCD_W-1:0] value,
    output logic             is_zero
);

    localparam logic [BCD_W-1:0] MAXV = BCD_W'(MOD - 1);

    logic [BCD_W-1:0] value_q;
    logic [BCD_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = bcd_clamp(din, MAXV);
        end else if (dec) begin
            value_d = (value_q == '0) ? MAXV : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign is_zero = (value_q == '0);

endmodule

// File: rtl/timer_bcd_down.sv
// -----------------------------------------------------------------------------
// timer_bcd_down
// Multi-digit BCD down-counter for the cook timer, optional mm:ss seconds-tens
// digit, hold-at-zero or wrap policy, and a one-cycle done pulse.
//   clk    in   system clock, rising edge
//   clrn   in   asynchronous active-low reset (count -> 0, done -> 0)
//   loadn  in   synchronous active-low load of `in` (clamped per digit)
//   en     in   count enable, one decrement per enabled edge
//   in     in   BCD load value, digit k at [4k+3:4k]
//   out    out  current BCD count
//   tc     out  en & (count == 0), combinational
//   zero   out  count == 0, combinational
//   done   out  registered pulse on the edge a decrement reaches zero
// -----------------------------------------------------------------------------
module timer_bcd_down
    import timer_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SEXAGESIMAL = 1,
    parameter int WRAP        = 0
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      loadn,
    input  logic                      en,
    input  logic [BCD_W*DIGITS-1:0]   in,
    output logic [BCD_W*DIGITS-1:0]   out,
    output logic                      tc,
    output logic                      zero,
    output logic                      done
);

    localparam bit   SEX_EN  = (SEXAGESIMAL != 0) && (DIGITS >= 2);
    localparam logic WRAP_EN = (WRAP != 0);

    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] lower_zero;
    logic [DIGITS-1:0] dec;
    logic              count_ok;
    logic              done_q;
    logic              done_d;

    assign zero = &is_zero;
    assign tc   = en & zero;

    // At all-zero every digit sees a full borrow chain, so letting the chain
    // run produces the all-maximum wrap value; blocking it gives hold-at-zero.
    assign count_ok = loadn & en & (~zero | WRAP_EN);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign lower_zero[gi] = 1'b1;
            end else begin : g_upper
                assign lower_zero[gi] = &is_zero[gi-1:0];
            end

            assign dec[gi] = count_ok & lower_zero[gi];

            timer_digit #(
                .MOD(digit_mod(gi, SEX_EN))
            ) u_digit (
                .clk     (clk),
                .clrn    (clrn),
                .load    (~loadn),
                .din     (in[BCD_W*gi +: BCD_W]),
                .dec     (dec[gi]),
                .value   (out[BCD_W*gi +: BCD_W]),
                .is_zero (is_zero[gi])
            );
        end
    endgenerate

    // A decrement lands on zero only from a count of exactly one.
    assign done_d = loadn & en & (out == (BCD_W*DIGITS)'(1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_timer_bcd_down.sv
module tb_timer_bcd_down;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        loadn = 1'b1;
    logic        en = 1'b0;
    logic [15:0] in4 = '0;
    logic [7:0]  in2 = '0;
    logic [3:0]  in1 = '0;
    logic [15:0] out4;
    logic [7:0]  out2;
    logic [3:0]  out1;
    logic        tc4, tc2, tc1, zero4, zero2, zero1, done4, done2, done1;

    always #5 clk = ~clk;

    timer_bcd_down #(.DIGITS(4), .SEXAGESIMAL(1), .WRAP(0)) dut4 (
        .clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .in(in4),
        .out(out4), .tc(tc4), .zero(zero4), .done(done4));
    timer_bcd_down #(.DIGITS(2), .SEXAGESIMAL(0), .WRAP(1)) dut2 (
        .clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .in(in2),
        .out(out2), .tc(tc2), .zero(zero2), .done(done2));
    timer_bcd_down #(.DIGITS(1), .SEXAGESIMAL(0), .WRAP(1)) dut1 (
        .clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .in(in1),
        .out(out1), .tc(tc1), .zero(zero1), .done(done1));

    // Reference configuration of the three instances.
    int DG[3]  = '{4, 2, 1};
    bit SXA[3] = '{1'b1, 1'b0, 1'b0};
    bit WRA[3] = '{1'b0, 1'b1, 1'b1};

    // Model state: count as a plain integer, done flag.
    int cnt[3];
    bit dn[3];
    int txn = 0;

    typedef struct {
        int          dut;
        int          txn;
        logic [15:0] out;
        logic        zero;
        logic        tc;
        logic        done;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    event chk_ev;

    function automatic int modof(int d, int k);
        return (SXA[d] && DG[d] >= 2 && k == 1) ? 6 : 10;
    endfunction

    function automatic int span(int d);
        int p = 1;
        for (int k = 0; k < DG[d]; k++) p = p * modof(d, k);
        return p;
    endfunction

    function automatic int bcd2int(int d, logic [15:0] v);
        int n = 0;
        int w = 1;
        for (int k = 0; k < DG[d]; k++) begin
            int nib = int'(v[4*k +: 4]);
            int m   = modof(d, k);
            if (nib > m - 1) nib = m - 1;
            n = n + nib * w;
            w = w * m;
        end
        return n;
    endfunction

    function automatic logic [15:0] int2bcd(int d, int n);
        logic [15:0] r = '0;
        int x = n;
        for (int k = 0; k < DG[d]; k++) begin
            r[4*k +: 4] = 4'(x % modof(d, k));
            x = x / modof(d, k);
        end
        return r;
    endfunction

    function automatic logic [15:0] in_of(int d);
        case (d)
            0:       return in4;
            1:       return {8'h00, in2};
            default: return {12'h000, in1};
        endcase
    endfunction

    task automatic push_all();
        for (int d = 0; d < 3; d++) begin
            exp_t e;
            e.dut  = d;
            e.txn  = txn;
            e.out  = int2bcd(d, cnt[d]);
            e.zero = (cnt[d] == 0);
            e.tc   = en && (cnt[d] == 0);
            e.done = dn[d];
            sbq.push_back(e);
        end
        txn++;
    endtask

    // One clock: drive inputs at the falling edge, advance the model to the
    // state expected after the next rising edge.
    task automatic cyc(bit ld, bit e, logic [15:0] v4, logic [7:0] v2, logic [3:0] v1);
        @(negedge clk);
        loadn = ~ld;
        en    = e;
        in4   = v4;
        in2   = v2;
        in1   = v1;
        for (int d = 0; d < 3; d++) begin
            if (ld) begin
                cnt[d] = bcd2int(d, in_of(d));
                dn[d]  = 1'b0;
            end else if (e) begin
                if (cnt[d] != 0) begin
                    cnt[d] = cnt[d] - 1;
                    dn[d]  = (cnt[d] == 0);
                end else begin
                    if (WRA[d]) cnt[d] = span(d) - 1;
                    dn[d] = 1'b0;
                end
            end else begin
                dn[d] = 1'b0;
            end
        end
        push_all();
    endtask

    // Reset between edges; the clear must be visible before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        clrn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            dn[d]  = 1'b0;
        end
        push_all();
        -> chk_ev;
        #4;
        clrn = 1'b1;
    endtask

    task automatic chk(string nm, int d, int t, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d txn %0d: got %h expected %h", nm, d, t, act, exp);
        end
    endtask

    // Monitor: after every rising edge (or an explicit reset probe) drain the
    // scoreboard and compare against the live outputs.
    initial begin
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (sbq.size() > 0) begin
                exp_t        e;
                logic [15:0] ao;
                logic        az, at, ad;
                e = sbq.pop_front();
                case (e.dut)
                    0:       begin ao = out4;            az = zero4; at = tc4; ad = done4; end
                    1:       begin ao = {8'h00, out2};   az = zero2; at = tc2; ad = done2; end
                    default: begin ao = {12'h000, out1}; az = zero1; at = tc1; ad = done1; end
                endcase
                $display("txn %0d dut%0d out=%h zero=%b tc=%b done=%b", e.txn, e.dut, ao, az, at, ad);
                chk("out",  e.dut, e.txn, ao, e.out);
                chk("zero", e.dut, e.txn, 16'(az), 16'(e.zero));
                chk("tc",   e.dut, e.txn, 16'(at), 16'(e.tc));
                chk("done", e.dut, e.txn, 16'(ad), 16'(e.done));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            dn[d]  = 1'b0;
        end

        do_reset();

        // Countdown from 1:00 / 01 / 9 through zero, hold and wrap.
        cyc(1'b1, 1'b1, 16'h0100, 8'h01, 4'h9);
        repeat (62) cyc(1'b0, 1'b1, 16'h0000, 8'h00, 4'h0);

        // Load clamping.
        cyc(1'b1, 1'b0, 16'h9999, 8'hAF, 4'hF);
        cyc(1'b1, 1'b1, 16'h00AF, 8'h5A, 4'hC);

        // Load beats enable.
        cyc(1'b1, 1'b1, 16'h0230, 8'h10, 4'h3);
        cyc(1'b0, 1'b1, 16'h0000, 8'h00, 4'h0);

        // Reset mid-count aborts with no done pulse.
        cyc(1'b1, 1'b1, 16'h0005, 8'h02, 4'h2);
        repeat (2) cyc(1'b0, 1'b1, 16'h0000, 8'h00, 4'h0);
        do_reset();
        repeat (3) cyc(1'b0, 1'b1, 16'h0000, 8'h00, 4'h0);

        // Loading zero never raises done; hold clears it.
        cyc(1'b1, 1'b1, 16'h0001, 8'h01, 4'h1);
        cyc(1'b0, 1'b1, 16'h0000, 8'h00, 4'h0);
        cyc(1'b1, 1'b0, 16'h0000, 8'h00, 4'h0);
        cyc(1'b0, 1'b0, 16'h0000, 8'h00, 4'h0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            bit          ld, e;
            logic [15:0] v4;
            logic [7:0]  v2;
            logic [3:0]  v1;
            if ($urandom_range(99) < 2) do_reset();
            ld = ($urandom_range(7) == 0);
            e  = ($urandom_range(3) != 0);
            v4 = ($urandom_range(1) == 1) ? 16'($urandom_range(3)) : 16'($urandom);
            v2 = 8'($urandom);
            v1 = 4'($urandom);
            cyc(ld, e, v4, v2, v1);
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
